// File: rtl/tp_cross_scheduler.sv
// tp_cross_scheduler: round-robin scheduler of tracklet-memory pages into the crossing processor.
// Define TP_SCHED_WDOG_EN to add the WAIT_ACK watchdog and the ERR state.
module tp_cross_scheduler #(
    parameter int NPAGE   = 4,
    parameter int PW      = 2,
    parameter int ACK_TMO = 15,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic [NPAGE-1:0] page_rdy,
    input  logic             proc_bsy,
    input  logic             err_clr,
    output logic             start_proc,
    output logic [PW-1:0]    page_sel,
    output logic [NPAGE-1:0] page_rel,
    output logic             sched_bsy,
    output logic [CNT_W-1:0] cross_cnt,
    output logic             sched_err
);
`ifdef TP_SCHED_WDOG_EN
    typedef enum logic [5:0] {
        IDLE = 6'b000001, START = 6'b000010, WAIT_ACK = 6'b000100,
        WAIT_DONE = 6'b001000, RELEASE = 6'b010000, ERR = 6'b100000
    } state_t;
    localparam int TW = $clog2(ACK_TMO + 1);
    logic [TW-1:0] tmr;
`else
    typedef enum logic [4:0] {
        IDLE = 5'b00001, START = 5'b00010, WAIT_ACK = 5'b00100,
        WAIT_DONE = 5'b01000, RELEASE = 5'b10000
    } state_t;
`endif
    state_t state, state_nx;
    logic [PW-1:0] last_gnt, gnt, idx;
    logic gnt_vld, rel_now;

    // Descending scan so the nearest ready page after last_gnt is the one left in gnt.
    always_comb begin
        gnt = '0;
        gnt_vld = 1'b0;
        idx = '0;
        for (int i = NPAGE; i >= 1; i--) begin
            idx = PW'((int'(last_gnt) + i) % NPAGE);
            if (page_rdy[idx]) begin
                gnt = idx;
                gnt_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (enable && gnt_vld) state_nx = START;
            START:     state_nx = WAIT_ACK;
`ifdef TP_SCHED_WDOG_EN
            WAIT_ACK:  state_nx = proc_bsy ? WAIT_DONE : (tmr == TW'(ACK_TMO - 1)) ? ERR : WAIT_ACK;
            ERR:       if (err_clr) state_nx = IDLE;
`else
            WAIT_ACK:  if (proc_bsy) state_nx = WAIT_DONE;
`endif
            WAIT_DONE: if (!proc_bsy) state_nx = RELEASE;
            RELEASE:   state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
            page_sel <= '0;
            last_gnt <= PW'(NPAGE - 1);
            cross_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == START) begin
                page_sel <= gnt;
                last_gnt <= gnt;
            end
            if (state == RELEASE) cross_cnt <= cross_cnt + CNT_W'(1);
        end
    end

`ifdef TP_SCHED_WDOG_EN
    // Timer is zero on every entry to WAIT_ACK because it is cleared in all other states.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) tmr <= '0;
        else tmr <= (state == WAIT_ACK) ? tmr + TW'(1) : '0;
    end
    assign rel_now   = (state == RELEASE) || (state == ERR && err_clr);
    assign sched_err = (state == ERR);
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign rel_now   = (state == RELEASE);
    assign sched_err = 1'b0;
`endif

    assign start_proc = (state == START);
    assign sched_bsy  = (state != IDLE);
    assign page_rel   = rel_now ? (NPAGE'(1) << page_sel) : '0;
endmodule
